// File: rtl/fw_spi_initiator_pkg.sv
// Shared register map, bit positions and shift-engine states for the SPI initiator.
package fw_spi_initiator_pkg;

    // Register select values, taken from rt_adr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_CLKDIV = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_CPOL = 1;
    localparam int CTRL_CPHA = 2;
    localparam int CTRL_TXIE = 3;
    localparam int CTRL_RXIE = 4;

    // STATUS bit positions
    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_BUSY     = 4;
    localparam int STAT_OVERRUN  = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } eng_state_t;

endpackage

// File: rtl/fw_spi_fifo.sv
// Synchronous 8-bit FIFO. A pop in the same cycle as a push on a full FIFO
// frees the slot first, so the push is still accepted.
module fw_spi_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic [7:0] i_wdata,
    input  logic       i_pop,
    output logic [7:0] o_rdata,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    // DEPTH is a power of two, so the count MSB alone marks full
    assign o_full    = r_count[AW];
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage, pointers and occupancy count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_do_pop) r_rptr <= r_rptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/fw_spi_initiator.sv
// Wishbone-mapped SPI initiator: register file, TX/RX FIFOs and a byte shift engine.
module fw_spi_initiator
    import fw_spi_initiator_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  rt_adr,
    input  logic [31:0] rt_dat_w,
    output logic [31:0] rt_dat_r,
    input  logic        rt_cyc,
    input  logic        rt_stb,
    input  logic        rt_we,
    input  logic [3:0]  rt_sel,
    output logic        rt_ack,
    output logic        rt_err,
    output logic        inta,
    output logic        tx_ready,
    output logic        rx_ready,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);
    // Bus-side registers
    logic        r_ack;
    logic [31:0] r_dat_r;
    logic [4:0]  r_ctrl;
    logic [7:0]  r_div;
    logic        r_ovr;

    // Shift engine registers
    eng_state_t  r_state, w_state_nx;
    logic [7:0]  r_sh;
    logic [7:0]  r_rx;
    logic [7:0]  r_hcnt;
    logic [3:0]  r_edge;
    logic [7:0]  r_div_l;
    logic        r_cpol;
    logic        r_cpha;
    logic        r_sck;
    logic        r_mosi;

    logic        w_req, w_ctrl_wr, w_stat_wr, w_div_wr, w_tx_push, w_rx_pop;
    logic        w_eng_pop, w_eng_push, w_half_end, w_busy, w_ovr_set;
    logic [7:0]  w_tx_data, w_rx_data;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [5:0]  w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused  = ^{rt_adr[1:0], rt_dat_w[31:8], rt_sel[3:1]};

    // A new access is accepted only while ack is low, giving one ack per 2 cycles
    assign w_req     = rt_cyc & rt_stb & ~r_ack;
    assign w_ctrl_wr = w_req & rt_we & (rt_adr[3:2] == REG_CTRL)   & rt_sel[0];
    assign w_stat_wr = w_req & rt_we & (rt_adr[3:2] == REG_STATUS) & rt_sel[0];
    assign w_div_wr  = w_req & rt_we & (rt_adr[3:2] == REG_CLKDIV) & rt_sel[0];
    assign w_tx_push = w_req & rt_we & (rt_adr[3:2] == REG_DATA)   & rt_sel[0];
    assign w_rx_pop  = w_req & ~rt_we & (rt_adr[3:2] == REG_DATA);

    fw_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_tx_push),
        .i_wdata (rt_dat_w[7:0]),
        .i_pop   (w_eng_pop),
        .o_rdata (w_tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    fw_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_eng_push),
        .i_wdata (r_rx),
        .i_pop   (w_rx_pop),
        .o_rdata (w_rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign w_busy    = (r_state != S_IDLE);
    // A same-cycle DATA read makes room, so that push is not an overrun
    assign w_ovr_set = w_eng_push & w_rx_full & ~w_rx_pop;
    assign w_status  = {r_ovr, w_busy, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    assign rt_ack    = r_ack;
    assign rt_dat_r  = r_dat_r;
    assign rt_err    = 1'b0;
    assign tx_ready  = ~w_tx_full;
    assign rx_ready  = ~w_rx_empty;
    assign sck       = r_sck;
    assign mosi      = r_mosi;
    assign inta      = (r_ctrl[CTRL_TXIE] & w_tx_empty) | (r_ctrl[CTRL_RXIE] & ~w_rx_empty) | r_ovr;

    // Read data mux, sampled into r_dat_r on the accepting edge
    always_comb begin
        w_rdata = '0;
        case (rt_adr[3:2])
            REG_CTRL:   w_rdata[4:0] = r_ctrl;
            REG_STATUS: w_rdata[5:0] = w_status;
            REG_DATA:   w_rdata[7:0] = w_rx_empty ? 8'h00 : w_rx_data;
            REG_CLKDIV: w_rdata[7:0] = r_div;
            default:    w_rdata      = '0;
        endcase
    end

    // Bus handshake, register writes and sticky overrun
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ack   <= 1'b0;
            r_dat_r <= '0;
            r_ctrl  <= '0;
            r_div   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_dat_r <= (w_req && !rt_we) ? w_rdata : 32'h0;
            if (w_ctrl_wr) r_ctrl <= rt_dat_w[4:0];
            if (w_div_wr)  r_div  <= rt_dat_w[7:0];
            // A new overrun wins over a clear in the same cycle
            if (w_ovr_set)                       r_ovr <= 1'b1;
            else if (w_stat_wr && rt_dat_w[5])   r_ovr <= 1'b0;
        end
    end

    // Engine state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // Engine next-state and FIFO strobes; clearing EN aborts LOAD/SHIFT
    always_comb begin
        w_state_nx = r_state;
        w_eng_pop  = 1'b0;
        w_eng_push = 1'b0;
        w_half_end = (r_hcnt == r_div_l);
        case (r_state)
            S_IDLE:  if (r_ctrl[CTRL_EN] && !w_tx_empty) w_state_nx = S_LOAD;
            S_LOAD: begin
                if (!r_ctrl[CTRL_EN]) w_state_nx = S_IDLE;
                else begin
                    w_eng_pop  = 1'b1;
                    w_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!r_ctrl[CTRL_EN])                    w_state_nx = S_IDLE;
                else if (w_half_end && r_edge == 4'd15)  w_state_nx = S_DONE;
            end
            S_DONE: begin
                w_eng_push = 1'b1;
                w_state_nx = (r_ctrl[CTRL_EN] && !w_tx_empty) ? S_LOAD : S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Engine datapath: sck generation, mosi shifting and miso capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sh    <= '0;
            r_rx    <= '0;
            r_hcnt  <= '0;
            r_edge  <= '0;
            r_div_l <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sck  <= r_ctrl[CTRL_CPOL];
                    r_mosi <= 1'b0;
                end
                S_LOAD: begin
                    r_cpol  <= r_ctrl[CTRL_CPOL];
                    r_cpha  <= r_ctrl[CTRL_CPHA];
                    r_div_l <= r_div;
                    r_rx    <= '0;
                    r_hcnt  <= '0;
                    r_edge  <= '0;
                    r_sck   <= r_ctrl[CTRL_CPOL];
                    // CPHA=0 presents bit7 now, so the register is pre-shifted;
                    // every later shift event then simply emits r_sh[7]
                    if (r_ctrl[CTRL_CPHA]) begin
                        r_sh   <= w_tx_data;
                        r_mosi <= 1'b0;
                    end else begin
                        r_sh   <= {w_tx_data[6:0], 1'b0};
                        r_mosi <= w_tx_data[7];
                    end
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        r_hcnt <= '0;
                        r_sck  <= ~r_sck;
                        r_edge <= r_edge + 4'd1;
                        // Even edges lead, odd edges trail; sample where parity matches CPHA
                        if (r_edge[0] == r_cpha) begin
                            r_rx <= {r_rx[6:0], miso};
                        end else begin
                            r_mosi <= r_sh[7];
                            r_sh   <= {r_sh[6:0], 1'b0};
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 8'd1;
                    end
                end
                S_DONE:  r_sck <= r_cpol;
                default: r_sck <= r_ctrl[CTRL_CPOL];
            endcase
            if (w_state_nx == S_IDLE) begin
                r_sck  <= r_ctrl[CTRL_CPOL];
                r_mosi <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fw_spi_initiator.sv
// Directed bench for fw_spi_initiator: register defaults, SPI modes 0/3,
// FIFO limits with overrun, interrupts, EN abort and async reset.
module tb_fw_spi_initiator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rt_adr = '0;
    logic [31:0] rt_dat_w = '0;
    logic [31:0] rt_dat_r;
    logic        rt_cyc = 1'b0, rt_stb = 1'b0, rt_we = 1'b0;
    logic [3:0]  rt_sel = '0;
    logic        rt_ack, rt_err, inta, tx_ready, rx_ready, sck, mosi, miso;
    logic        loop_en = 1'b1;
    logic        miso_drv = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    assign miso = loop_en ? mosi : miso_drv;

    always #5 clock = ~clock;

    fw_spi_initiator #(.FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .rt_adr(rt_adr), .rt_dat_w(rt_dat_w),
        .rt_dat_r(rt_dat_r), .rt_cyc(rt_cyc), .rt_stb(rt_stb), .rt_we(rt_we),
        .rt_sel(rt_sel), .rt_ack(rt_ack), .rt_err(rt_err), .inta(inta),
        .tx_ready(tx_ready), .rx_ready(rx_ready), .sck(sck), .mosi(mosi), .miso(miso)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic got;
        @(negedge clock);
        rt_adr = a; rt_dat_w = d; rt_sel = s; rt_we = 1'b1; rt_cyc = 1'b1; rt_stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (rt_ack) begin got = 1'b1; break; end
        end
        rt_cyc = 1'b0; rt_stb = 1'b0; rt_we = 1'b0;
        chk("wr_ack", {31'b0, got}, 32'h1);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        logic got;
        @(negedge clock);
        rt_adr = a; rt_sel = 4'hF; rt_we = 1'b0; rt_cyc = 1'b1; rt_stb = 1'b1;
        got = 1'b0;
        d = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (rt_ack) begin got = 1'b1; d = rt_dat_r; break; end
        end
        rt_cyc = 1'b0; rt_stb = 1'b0;
        chk("rd_ack", {31'b0, got}, 32'h1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  bits;
        logic        psck, pmosi, win;
        int          rises, toggles, bad, c_first, c_last;

        // ---- reset defaults ----
        #12;
        chk("rst_ack", {31'b0, rt_ack}, 32'h0);
        chk("rst_dat_r", rt_dat_r, 32'h0);
        chk("rst_sck", {31'b0, sck}, 32'h0);
        chk("rst_mosi", {31'b0, mosi}, 32'h0);
        reset = 1'b1;
        idle(2);
        chk("rst_tx_ready", {31'b0, tx_ready}, 32'h1);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        chk("rst_inta", {31'b0, inta}, 32'h0);
        chk("rst_err", {31'b0, rt_err}, 32'h0);
        bus_read(4'h0, rd); chk("rst_ctrl", rd, 32'h0);
        bus_read(4'h4, rd); chk("rst_status", rd, 32'h0A);
        bus_read(4'h8, rd); chk("rst_data", rd, 32'h0);
        bus_read(4'hC, rd); chk("rst_clkdiv", rd, 32'h0);
        chk("idle_dat_r", rt_dat_r, 32'h0);

        // ---- mode 0 loopback, DIV=1 ----
        bus_write(4'hC, 32'h1, 4'h1);
        bus_write(4'h0, 32'h1, 4'h1);
        bus_read(4'h0, rd); chk("ctrl_rb", rd, 32'h1);
        bus_write(4'h8, 32'hA5, 4'h1);
        psck = sck; rises = 0; bits = '0; c_first = 0; c_last = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (!psck && sck) begin
                if (rises == 0) c_first = i;
                c_last = i;
                bits = {bits[6:0], mosi};
                rises++;
            end
            psck = sck;
        end
        chk("m0_rises", rises, 32'd8);
        chk("m0_mosi_bits", {24'b0, bits}, 32'hA5);
        chk("m0_period", c_last - c_first, 32'd28);
        bus_read(4'h8, rd); chk("m0_rx", rd, 32'hA5);
        bus_read(4'h4, rd); chk("m0_status", rd, 32'h0A);

        // ---- mode 3, miso held high ----
        loop_en = 1'b0; miso_drv = 1'b1;
        bus_write(4'h0, 32'h7, 4'h1);
        idle(2);
        chk("m3_sck_idle", {31'b0, sck}, 32'h1);
        bus_write(4'h8, 32'h3C, 4'h1);
        psck = sck; pmosi = mosi; rises = 0; bits = '0; bad = 0; win = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (win && rises < 8 && mosi != pmosi && !(psck && !sck)) bad++;
            if (psck && !sck) win = 1'b1;
            if (!psck && sck) begin
                bits = {bits[6:0], mosi};
                rises++;
            end
            psck = sck; pmosi = mosi;
        end
        chk("m3_rises", rises, 32'd8);
        chk("m3_mosi_bits", {24'b0, bits}, 32'h3C);
        chk("m3_mosi_on_fall", bad, 32'd0);
        chk("m3_sck_end", {31'b0, sck}, 32'h1);
        bus_read(4'h8, rd); chk("m3_rx", rd, 32'hFF);
        bus_write(4'h0, 32'h0, 4'h1);
        loop_en = 1'b1; miso_drv = 1'b0;

        // ---- FIFO limits and overrun ----
        bus_write(4'hC, 32'h0, 4'h1);
        bus_write(4'h8, 32'h11, 4'h1);
        bus_write(4'h8, 32'h22, 4'h1);
        bus_write(4'h8, 32'h33, 4'h1);
        chk("txr_after3", {31'b0, tx_ready}, 32'h1);
        bus_write(4'h8, 32'h44, 4'h1);
        chk("txr_after4", {31'b0, tx_ready}, 32'h0);
        bus_write(4'h8, 32'h55, 4'h1);
        chk("txr_after5", {31'b0, tx_ready}, 32'h0);
        bus_read(4'h4, rd); chk("full_status", rd, 32'h09);
        bus_write(4'h0, 32'h1, 4'h1);
        psck = sck; rises = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!psck && sck) rises++;
            psck = sck;
        end
        chk("b2b_rises", rises, 32'd32);
        bus_read(4'h4, rd); chk("rxfull_status", rd, 32'h06);
        chk("rxfull_inta", {31'b0, inta}, 32'h0);
        bus_write(4'h8, 32'h66, 4'h1);
        idle(60);
        chk("ovr_inta", {31'b0, inta}, 32'h1);
        bus_read(4'h4, rd); chk("ovr_status", rd, 32'h26);
        bus_write(4'h4, 32'h20, 4'h1);
        chk("ovr_clr_inta", {31'b0, inta}, 32'h0);
        bus_read(4'h4, rd); chk("ovr_clr_status", rd, 32'h06);
        bus_read(4'h8, rd); chk("rx0", rd, 32'h11);
        bus_read(4'h8, rd); chk("rx1", rd, 32'h22);
        bus_read(4'h8, rd); chk("rx2", rd, 32'h33);
        bus_read(4'h8, rd); chk("rx3", rd, 32'h44);
        chk("rx_drained", {31'b0, rx_ready}, 32'h0);
        bus_read(4'h8, rd); chk("rx_empty_read", rd, 32'h0);

        // ---- interrupts ----
        bus_write(4'h0, 32'h11, 4'h1);
        chk("rxie_idle_inta", {31'b0, inta}, 32'h0);
        bus_write(4'h8, 32'h5A, 4'h1);
        bad = 0; win = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (rx_ready) begin win = 1'b1; break; end
            if (inta) bad++;
        end
        chk("rxie_seen_push", {31'b0, win}, 32'h1);
        chk("rxie_early_inta", bad, 32'd0);
        chk("rxie_inta", {31'b0, inta}, 32'h1);
        bus_read(4'h8, rd); chk("rxie_data", rd, 32'h5A);
        chk("rxie_inta_fall", {31'b0, inta}, 32'h0);
        bus_write(4'h0, 32'h08, 4'h1);
        chk("txie_inta", {31'b0, inta}, 32'h1);
        bus_write(4'h0, 32'h0, 4'h1);
        chk("txie_off_inta", {31'b0, inta}, 32'h0);

        // ---- abort by clearing EN at the 3rd sck edge ----
        bus_write(4'hC, 32'h3, 4'h1);
        bus_write(4'h0, 32'h1, 4'h1);
        bus_write(4'h8, 32'hF0, 4'h1);
        psck = sck; toggles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (sck != psck) toggles++;
            psck = sck;
            if (toggles == 3) break;
        end
        chk("abort_edges", toggles, 32'd3);
        bus_write(4'h0, 32'h0, 4'h1);
        idle(2);
        chk("abort_sck", {31'b0, sck}, 32'h0);
        chk("abort_mosi", {31'b0, mosi}, 32'h0);
        bus_read(4'h4, rd); chk("abort_status", rd, 32'h0A);
        idle(80);
        chk("abort_rx_ready", {31'b0, rx_ready}, 32'h0);

        // ---- async reset mid-transfer ----
        bus_write(4'h0, 32'h3, 4'h1);
        bus_write(4'h8, 32'h81, 4'h1);
        bus_write(4'h8, 32'h7E, 4'h1);
        idle(10);
        #2 reset = 1'b0;
        #1;
        chk("arst_sck", {31'b0, sck}, 32'h0);
        chk("arst_tx_ready", {31'b0, tx_ready}, 32'h1);
        chk("arst_rx_ready", {31'b0, rx_ready}, 32'h0);
        chk("arst_inta", {31'b0, inta}, 32'h0);
        idle(2);
        reset = 1'b1;
        bus_read(4'h0, rd); chk("arst_ctrl", rd, 32'h0);
        bus_read(4'h4, rd); chk("arst_status", rd, 32'h0A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
